// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: execute-side inputs, memory-side registered outputs.
// The design side uses the slave modport; the producer/observer uses master.
interface ex_mem_reg_if;
   logic [31:0] nextPC_in, aluResult_in, leapAddr_in, memVal_in;
   logic [63:0] fbusW_in;
   logic [4:0]  destReg_in, fDestReg_in;
   logic [1:0]  DSize_in;
   logic        leap_in, PCtoReg_in, RegToPC_in, RegWrite_in, MemToReg_in;
   logic        MemWrite_in, loadSign_in, FPRegWrite_in, mul_in;
   logic        stall_in, hold_in;

   logic [31:0] nextPC_out, aluResult_out, leapAddr_out, memVal_out;
   logic [63:0] fbusW_out;
   logic [4:0]  destReg_out, fDestReg_out;
   logic [1:0]  DSize_out;
   logic        leap_out, PCtoReg_out, RegToPC_out, RegWrite_out, MemToReg_out;
   logic        MemWrite_out, loadSign_out, FPRegWrite_out, mul_out;
   logic        valid_out, leap_fire_out;
   logic [15:0] bubble_cnt_out;

   modport slave (
      input  nextPC_in, aluResult_in, leapAddr_in, memVal_in, fbusW_in,
             destReg_in, fDestReg_in, DSize_in,
             leap_in, PCtoReg_in, RegToPC_in, RegWrite_in, MemToReg_in,
             MemWrite_in, loadSign_in, FPRegWrite_in, mul_in,
             stall_in, hold_in,
      output nextPC_out, aluResult_out, leapAddr_out, memVal_out, fbusW_out,
             destReg_out, fDestReg_out, DSize_out,
             leap_out, PCtoReg_out, RegToPC_out, RegWrite_out, MemToReg_out,
             MemWrite_out, loadSign_out, FPRegWrite_out, mul_out,
             valid_out, leap_fire_out, bubble_cnt_out
   );

   modport master (
      output nextPC_in, aluResult_in, leapAddr_in, memVal_in, fbusW_in,
             destReg_in, fDestReg_in, DSize_in,
             leap_in, PCtoReg_in, RegToPC_in, RegWrite_in, MemToReg_in,
             MemWrite_in, loadSign_in, FPRegWrite_in, mul_in,
             stall_in, hold_in,
      input  nextPC_out, aluResult_out, leapAddr_out, memVal_out, fbusW_out,
             destReg_out, fDestReg_out, DSize_out,
             leap_out, PCtoReg_out, RegToPC_out, RegWrite_out, MemToReg_out,
             MemWrite_out, loadSign_out, FPRegWrite_out, mul_out,
             valid_out, leap_fire_out, bubble_cnt_out
   );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with hold (freeze), stall (bubble insertion), a saturating
// bubble counter and a one-shot leap redirect pulse.
module ex_mem_reg (
   input  logic         clk,
   input  logic         reset,
   ex_mem_reg_if.slave  io_bus
);

   typedef enum logic {StNotFired, StFired} fired_e;

   logic [31:0] r_next_pc, r_alu_result, r_leap_addr, r_mem_val;
   logic [63:0] r_fbus_w;
   logic [4:0]  r_dest_reg, r_fdest_reg;
   logic [1:0]  r_dsize;
   logic        r_leap, r_pc_to_reg, r_reg_to_pc, r_reg_write, r_mem_to_reg;
   logic        r_mem_write, r_load_sign, r_fp_reg_write, r_mul;
   logic        r_valid;
   logic [15:0] r_bubble_cnt;
   fired_e      r_fired, w_fired_next;

   logic w_bubble;
   logic w_keep_ctrl;

   assign w_bubble    = ~io_bus.hold_in & io_bus.stall_in;
   assign w_keep_ctrl = ~io_bus.stall_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_next_pc      <= '0;
         r_alu_result   <= '0;
         r_leap_addr    <= '0;
         r_mem_val      <= '0;
         r_fbus_w       <= '0;
         r_dest_reg     <= '0;
         r_fdest_reg    <= '0;
         r_dsize        <= '0;
         r_leap         <= 1'b0;
         r_pc_to_reg    <= 1'b0;
         r_reg_to_pc    <= 1'b0;
         r_reg_write    <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_mem_write    <= 1'b0;
         r_load_sign    <= 1'b0;
         r_fp_reg_write <= 1'b0;
         r_mul          <= 1'b0;
         r_valid        <= 1'b0;
      end else if (!io_bus.hold_in) begin
         // Data fields load on both capture and bubble; only side effects are squashed.
         r_next_pc      <= io_bus.nextPC_in;
         r_alu_result   <= io_bus.aluResult_in;
         r_leap_addr    <= io_bus.leapAddr_in;
         r_mem_val      <= io_bus.memVal_in;
         r_fbus_w       <= io_bus.fbusW_in;
         r_dest_reg     <= io_bus.destReg_in;
         r_fdest_reg    <= io_bus.fDestReg_in;
         r_dsize        <= io_bus.DSize_in;
         r_load_sign    <= io_bus.loadSign_in;
         r_leap         <= io_bus.leap_in       & w_keep_ctrl;
         r_pc_to_reg    <= io_bus.PCtoReg_in    & w_keep_ctrl;
         r_reg_to_pc    <= io_bus.RegToPC_in    & w_keep_ctrl;
         r_reg_write    <= io_bus.RegWrite_in   & w_keep_ctrl;
         r_mem_to_reg   <= io_bus.MemToReg_in   & w_keep_ctrl;
         r_mem_write    <= io_bus.MemWrite_in   & w_keep_ctrl;
         r_fp_reg_write <= io_bus.FPRegWrite_in & w_keep_ctrl;
         r_mul          <= io_bus.mul_in        & w_keep_ctrl;
         r_valid        <= w_keep_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= '0;
      end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fired <= StNotFired;
      end else begin
         r_fired <= w_fired_next;
      end
   end

   // Any hold cycle means the pulse for the occupant was already issued.
   always_comb begin
      w_fired_next = StNotFired;
      if (io_bus.hold_in) begin
         w_fired_next = StFired;
      end
   end

   assign io_bus.nextPC_out     = r_next_pc;
   assign io_bus.aluResult_out  = r_alu_result;
   assign io_bus.leapAddr_out   = r_leap_addr;
   assign io_bus.memVal_out     = r_mem_val;
   assign io_bus.fbusW_out      = r_fbus_w;
   assign io_bus.destReg_out    = r_dest_reg;
   assign io_bus.fDestReg_out   = r_fdest_reg;
   assign io_bus.DSize_out      = r_dsize;
   assign io_bus.leap_out       = r_leap;
   assign io_bus.PCtoReg_out    = r_pc_to_reg;
   assign io_bus.RegToPC_out    = r_reg_to_pc;
   assign io_bus.RegWrite_out   = r_reg_write;
   assign io_bus.MemToReg_out   = r_mem_to_reg;
   assign io_bus.MemWrite_out   = r_mem_write;
   assign io_bus.loadSign_out   = r_load_sign;
   assign io_bus.FPRegWrite_out = r_fp_reg_write;
   assign io_bus.mul_out        = r_mul;
   assign io_bus.valid_out      = r_valid;
   assign io_bus.bubble_cnt_out = r_bubble_cnt;
   assign io_bus.leap_fire_out  = r_leap & r_valid & (r_fired == StNotFired);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized scoreboard bench for ex_mem_reg: a behavioural model queues the expected
// outputs per edge and a monitor compares them; directed scenarios add constant checks.
module tb_ex_mem_reg;

   typedef struct packed {
      logic [31:0] nextpc, alu, leapaddr, memval;
      logic [63:0] fbus;
      logic [4:0]  dest, fdest;
      logic [1:0]  dsize;
      logic        leap, pctoreg, regtopc, regwrite, memtoreg;
      logic        memwrite, loadsign, fpregwrite, mul;
   } pay_t;

   typedef struct packed {
      pay_t        pay;
      logic        valid, fire;
      logic [15:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ex_mem_reg_if bus ();

   ex_mem_reg dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   obs_t  m;
   logic  m_fired;
   obs_t  exp_q[$];
   string name_q[$];

   function automatic obs_t read_dut();
      obs_t o;
      o.pay.nextpc     = bus.nextPC_out;
      o.pay.alu        = bus.aluResult_out;
      o.pay.leapaddr   = bus.leapAddr_out;
      o.pay.memval     = bus.memVal_out;
      o.pay.fbus       = bus.fbusW_out;
      o.pay.dest       = bus.destReg_out;
      o.pay.fdest      = bus.fDestReg_out;
      o.pay.dsize      = bus.DSize_out;
      o.pay.leap       = bus.leap_out;
      o.pay.pctoreg    = bus.PCtoReg_out;
      o.pay.regtopc    = bus.RegToPC_out;
      o.pay.regwrite   = bus.RegWrite_out;
      o.pay.memtoreg   = bus.MemToReg_out;
      o.pay.memwrite   = bus.MemWrite_out;
      o.pay.loadsign   = bus.loadSign_out;
      o.pay.fpregwrite = bus.FPRegWrite_out;
      o.pay.mul        = bus.mul_out;
      o.valid          = bus.valid_out;
      o.fire           = bus.leap_fire_out;
      o.cnt            = bus.bubble_cnt_out;
      return o;
   endfunction

   function automatic pay_t rand_pay();
      pay_t p;
      p.nextpc     = $urandom;
      p.alu        = $urandom;
      p.leapaddr   = $urandom;
      p.memval     = $urandom;
      p.fbus       = {$urandom, $urandom};
      p.dest       = 5'($urandom);
      p.fdest      = 5'($urandom);
      p.dsize      = 2'($urandom);
      p.leap       = 1'($urandom);
      p.pctoreg    = 1'($urandom);
      p.regtopc    = 1'($urandom);
      p.regwrite   = 1'($urandom);
      p.memtoreg   = 1'($urandom);
      p.memwrite   = 1'($urandom);
      p.loadsign   = 1'($urandom);
      p.fpregwrite = 1'($urandom);
      p.mul        = 1'($urandom);
      return p;
   endfunction

   task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic drive(input logic h, input logic s, input pay_t p);
      bus.hold_in       = h;
      bus.stall_in      = s;
      bus.nextPC_in     = p.nextpc;
      bus.aluResult_in  = p.alu;
      bus.leapAddr_in   = p.leapaddr;
      bus.memVal_in     = p.memval;
      bus.fbusW_in      = p.fbus;
      bus.destReg_in    = p.dest;
      bus.fDestReg_in   = p.fdest;
      bus.DSize_in      = p.dsize;
      bus.leap_in       = p.leap;
      bus.PCtoReg_in    = p.pctoreg;
      bus.RegToPC_in    = p.regtopc;
      bus.RegWrite_in   = p.regwrite;
      bus.MemToReg_in   = p.memtoreg;
      bus.MemWrite_in   = p.memwrite;
      bus.loadSign_in   = p.loadsign;
      bus.FPRegWrite_in = p.fpregwrite;
      bus.mul_in        = p.mul;
   endtask

   // Reference behaviour: what the stage holds after one edge with these inputs.
   task automatic model_step(input logic r, input logic h, input logic s, input pay_t p);
      pay_t q;
      if (r) begin
         m       = '0;
         m_fired = 1'b0;
      end else if (h) begin
         m_fired = 1'b1;
      end else begin
         q = p;
         if (s) begin
            {q.regwrite, q.memwrite, q.fpregwrite, q.pctoreg} = 4'b0;
            {q.regtopc, q.memtoreg, q.leap, q.mul}            = 4'b0;
            if (m.cnt < 16'hFFFF) m.cnt = m.cnt + 16'd1;
         end
         m.pay   = q;
         m.valid = !s;
         m_fired = 1'b0;
      end
      m.fire = m.pay.leap && m.valid && !m_fired;
   endtask

   task automatic step(input string nm, input logic r, input logic h, input logic s,
                       input pay_t p);
      @(negedge clk);
      reset = r;
      drive(h, s, p);
      model_step(r, h, s, p);
      exp_q.push_back(m);
      name_q.push_back(nm);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      obs_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk_obs(nm, read_dut(), e);
         end
      end
   end

   initial begin : stimulus
      pay_t p;
      int   fires;
      m       = '0;
      m_fired = 1'b0;
      drive(1'b0, 1'b0, '0);

      step("reset0", 1'b1, 1'b0, 1'b0, rand_pay());
      step("reset1", 1'b1, 1'b1, 1'b1, rand_pay());
      chk_val("reset_valid", 64'(bus.valid_out), 64'd0);
      chk_val("reset_cnt", 64'(bus.bubble_cnt_out), 64'd0);

      // Basic capture
      p = rand_pay();
      p.alu = 32'h0000_1234; p.dest = 5'd7; p.regwrite = 1'b1;
      step("capture", 1'b0, 1'b0, 1'b0, p);
      chk_val("cap_alu", 64'(bus.aluResult_out), 64'h1234);
      chk_val("cap_dest", 64'(bus.destReg_out), 64'd7);
      chk_val("cap_regwrite", 64'(bus.RegWrite_out), 64'd1);
      chk_val("cap_valid", 64'(bus.valid_out), 64'd1);

      // Three bubbles
      for (int i = 0; i < 3; i++) begin
         p = rand_pay();
         p.regwrite = 1'b1; p.memwrite = 1'b1;
         step("bubble", 1'b0, 1'b0, 1'b1, p);
         chk_val("bub_ctrl", 64'({bus.RegWrite_out, bus.MemWrite_out, bus.valid_out}), 64'd0);
      end
      chk_val("bub_cnt", 64'(bus.bubble_cnt_out), 64'd3);

      // Leap captured, then held: exactly one redirect pulse
      p = rand_pay();
      p.leap = 1'b1; p.leapaddr = 32'h0000_0040;
      step("leap_cap", 1'b0, 1'b0, 1'b0, p);
      fires = int'(bus.leap_fire_out);
      for (int i = 0; i < 4; i++) begin
         step("leap_hold", 1'b0, 1'b1, 1'($urandom), rand_pay());
         fires += int'(bus.leap_fire_out);
         chk_val("hold_leapaddr", 64'(bus.leapAddr_out), 64'h40);
      end
      chk_val("leap_pulses", 64'(fires), 64'd1);
      chk_val("hold_cnt", 64'(bus.bubble_cnt_out), 64'd3);

      // Hold wins over stall
      step("hold_stall", 1'b0, 1'b1, 1'b1, rand_pay());
      step("hold_stall", 1'b0, 1'b1, 1'b1, rand_pay());
      chk_val("prio_cnt", 64'(bus.bubble_cnt_out), 64'd3);
      chk_val("prio_leapaddr", 64'(bus.leapAddr_out), 64'h40);

      // Back-to-back leaps pulse every cycle
      for (int i = 0; i < 2; i++) begin
         p = rand_pay();
         p.leap = 1'b1;
         step("leap_b2b", 1'b0, 1'b0, 1'b0, p);
         chk_val("b2b_fire", 64'(bus.leap_fire_out), 64'd1);
      end

      // Reset in the middle of a hold with a valid occupant
      step("pre_rst_cap", 1'b0, 1'b0, 1'b0, rand_pay());
      step("rst_mid_hold", 1'b1, 1'b1, 1'b1, rand_pay());
      chk_obs("rst_all_zero", read_dut(), '0);
      p = rand_pay();
      step("post_rst_cap", 1'b0, 1'b0, 1'b0, p);
      chk_val("post_rst_alu", 64'(bus.aluResult_out), 64'(p.alu));
      chk_val("post_rst_valid", 64'(bus.valid_out), 64'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("random", ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), rand_pay());
      end

      // Saturation: 65535 bubbles, then two more
      step("sat_reset", 1'b1, 1'b0, 1'b0, rand_pay());
      for (int i = 0; i < 65535; i++) step("sat_fill", 1'b0, 1'b0, 1'b1, rand_pay());
      chk_val("sat_full", 64'(bus.bubble_cnt_out), 64'hFFFF);
      step("sat_over", 1'b0, 1'b0, 1'b1, rand_pay());
      step("sat_over", 1'b0, 1'b0, 1'b1, rand_pay());
      chk_val("sat_hold", 64'(bus.bubble_cnt_out), 64'hFFFF);

      // Stall release captures on the same edge
      p = rand_pay();
      step("stall_release", 1'b0, 1'b0, 1'b0, p);
      chk_val("release_valid", 64'(bus.valid_out), 64'd1);

      repeat (3) @(posedge clk);
      #3;
      chk_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Clocking and reset: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 Pass-through data inputs: nextPC_in, aluResult_in, leapAddr_in, memVal_in (each 32 bits); fbusW_in (64 bits); destReg_in, fDestReg_in (each 5 bits); DSize_in (2 bits).
REQ-005 Control inputs, 1 bit each: leap_in, PCtoReg_in, RegToPC_in, RegWrite_in, MemToReg_in, MemWrite_in, loadSign_in, FPRegWrite_in, mul_in.
REQ-006 stall_in  in  1  execute not finished (multiplier busy); insert a bubble.
REQ-007 hold_in  in  1  downstream memory stage busy; freeze the register.
REQ-008 Registered outputs: one *_out per REQ-004/005 input, same width.
REQ-009 valid_out  out  1  stage holds a real instruction.
REQ-010 leap_fire_out  out  1  one-cycle redirect pulse to fetch.
REQ-011 bubble_cnt_out  out  16  saturating count of inserted bubbles.

Function
REQ-012 Priority on each clock edge: reset > hold_in > stall_in > capture.
REQ-013 Capture (hold_in=0, stall_in=0):
- Load every *_in into its *_out.
- valid_out becomes 1.
- Latency is exactly one cycle.
REQ-014 Hold (hold_in=1):
- Every *_out, valid_out and bubble_cnt_out keeps its value.
- stall_in is ignored.
REQ-015 Bubble (hold_in=0, stall_in=1):
- Clear RegWrite_out, MemWrite_out, FPRegWrite_out, PCtoReg_out, RegToPC_out, MemToReg_out, leap_out, mul_out and valid_out to 0.
- Data outputs capture their inputs normally.
REQ-016 A bubble cycle increments bubble_cnt_out by 1.
REQ-017 bubble_cnt_out saturates at 16'hFFFF; it does not wrap.
REQ-018 The block tracks a one-bit state, fired (FIRED/NOT_FIRED).
- On capture: fired becomes 0.
- On hold: fired becomes 1.
- On bubble: fired becomes 0.
REQ-019 leap_fire_out = leap_out & valid_out & ~fired.
- Consequence: one pulse per captured leap, even when hold_in extends the occupancy.
REQ-020 Back-to-back captures with leap_in=1 produce a pulse in each cycle; no merging.
REQ-021 The 64-bit fbusW_out is captured as a whole word; no partial update.
REQ-022 Transition from stall_in=1 to stall_in=0 with hold_in=0: capture that same edge; no extra bubble.
REQ-023 No combinational path from any *_in to any *_out.

Reset
REQ-024 reset=1 at a clock edge forces all of the following to 0:
- every *_out;
- valid_out;
- leap_fire_out (via fired=0 and leap_out=0);
- bubble_cnt_out.
REQ-025 Reset overrides hold_in and stall_in in the same cycle, including mid-hold and mid-stall.
REQ-026 The first capture after reset deassertion occurs on the next edge.

Verification
REQ-027 Capture:
- Stimulus: reset, then aluResult_in=32'h0000_1234, destReg_in=5'd7, RegWrite_in=1, stall_in=0, hold_in=0.
- Required response after 1 edge: aluResult_out=32'h0000_1234, destReg_out=7, RegWrite_out=1, valid_out=1.
REQ-028 Bubble:
- Stimulus: stall_in=1 for 3 cycles with RegWrite_in=1, MemWrite_in=1.
- Required response: RegWrite_out=0, MemWrite_out=0, valid_out=0 each cycle; bubble_cnt_out=3.
REQ-029 Hold with leap:
- Stimulus: capture leap_in=1, leapAddr_in=32'h0000_0040, then hold_in=1 for 4 cycles.
- Required response: leap_fire_out high for exactly 1 cycle; leapAddr_out stays 32'h40 throughout; bubble_cnt_out unchanged.
REQ-030 Priority:
- Stimulus: hold_in=1 and stall_in=1 together for 2 cycles.
- Required response: outputs frozen at the prior values; bubble_cnt_out unchanged.
REQ-031 Saturation:
- Stimulus: preload via 65535 bubbles, then 2 more bubbles.
- Required response: bubble_cnt_out=16'hFFFF.
REQ-032 Reset mid-operation:
- Stimulus: reset=1 during hold_in=1 with valid_out=1.
- Required response after the edge: all outputs 0; next capture works normally.
